// File: rtl/semaforo_ruas.sv
// Round-robin traffic-light controller for N_RUAS streets with min/max green,
// fixed yellow and an all-red clearance interval; lamps are registered Moore outputs.
module semaforo_ruas #(
    parameter int unsigned N_RUAS      = 2,
    parameter int unsigned T_VERDE     = 4,
    parameter int unsigned T_MAX_VERDE = 8,
    parameter int unsigned T_AMARELO   = 2,
    parameter int unsigned T_VERMELHO  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_RUAS-1:0]         sensor,
    output logic [N_RUAS-1:0]         verde,
    output logic [N_RUAS-1:0]         amarelo,
    output logic [N_RUAS-1:0]         vermelho,
    output logic [$clog2(N_RUAS)-1:0] rua_ativa
);

    localparam int unsigned RW      = $clog2(N_RUAS);
    localparam int unsigned T_MAX_A = (T_MAX_VERDE > T_AMARELO) ? T_MAX_VERDE : T_AMARELO;
    localparam int unsigned T_MAX   = (T_MAX_A > T_VERMELHO) ? T_MAX_A : T_VERMELHO;
    localparam int unsigned CW      = $clog2(T_MAX + 1);

    localparam logic [N_RUAS-1:0] RST_VERDE = {{(N_RUAS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        VERDE,
        AMARELO,
        TODOS_VERMELHO
    } estado_t;

    estado_t           estado, estado_d;
    logic [RW-1:0]     proxima, proxima_d, rua_d, rr;
    logic [CW-1:0]     cnt, cnt_d;
    logic [N_RUAS-1:0] outros;
    logic              achou;
    logic [N_RUAS-1:0] verde_d, amarelo_d, vermelho_d;

    // Requests from other streets and the round-robin pick starting after rua_ativa.
    always_comb begin
        outros = '0;
        for (int i = 0; i < int'(N_RUAS); i++) begin
            outros[i] = sensor[i] && (RW'(i) != rua_ativa);
        end
        rr    = rua_ativa;
        achou = 1'b0;
        for (int k = 1; k < int'(N_RUAS); k++) begin
            if (!achou && outros[RW'((32'(rua_ativa) + 32'(k)) % N_RUAS)]) begin
                rr    = RW'((32'(rua_ativa) + 32'(k)) % N_RUAS);
                achou = 1'b1;
            end
        end
    end

    // Next-state logic and lamp decode of the next state.
    always_comb begin
        estado_d  = estado;
        rua_d     = rua_ativa;
        proxima_d = proxima;
        cnt_d     = (&cnt) ? cnt : cnt + CW'(1);

        case (estado)
            VERDE: begin
                if ((outros != '0) && (cnt >= CW'(T_VERDE - 1)) &&
                    (!sensor[rua_ativa] || (cnt >= CW'(T_MAX_VERDE - 1)))) begin
                    estado_d  = AMARELO;
                    proxima_d = rr;
                    cnt_d     = '0;
                end
            end
            AMARELO: begin
                if (cnt == CW'(T_AMARELO - 1)) begin
                    estado_d = TODOS_VERMELHO;
                    cnt_d    = '0;
                end
            end
            TODOS_VERMELHO: begin
                if (cnt == CW'(T_VERMELHO - 1)) begin
                    estado_d = VERDE;
                    rua_d    = proxima;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = VERDE;
                cnt_d    = '0;
            end
        endcase

        verde_d    = '0;
        amarelo_d  = '0;
        vermelho_d = '1;
        case (estado_d)
            VERDE: begin
                verde_d[rua_d]    = 1'b1;
                vermelho_d[rua_d] = 1'b0;
            end
            AMARELO: begin
                amarelo_d[rua_d]  = 1'b1;
                vermelho_d[rua_d] = 1'b0;
            end
            default: ;
        endcase
    end

    // State and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado    <= VERDE;
            rua_ativa <= '0;
            proxima   <= '0;
            cnt       <= '0;
            verde     <= RST_VERDE;
            amarelo   <= '0;
            vermelho  <= ~RST_VERDE;
        end else begin
            estado    <= estado_d;
            rua_ativa <= rua_d;
            proxima   <= proxima_d;
            cnt       <= cnt_d;
            verde     <= verde_d;
            amarelo   <= amarelo_d;
            vermelho  <= vermelho_d;
        end
    end

endmodule

// File: tb/tb_semaforo_ruas.sv
// Directed-vector bench for semaforo_ruas with N_RUAS=2 and default timing.
module tb_semaforo_ruas;

    logic       clk;
    logic       rst_n;
    logic [1:0] sensor;
    logic [1:0] verde, amarelo, vermelho;
    logic [0:0] rua_ativa;

    int n_chk  = 0;
    int n_pass = 0;

    // Lamp patterns as {verde, amarelo, vermelho}.
    localparam logic [5:0] G0 = 6'b01_00_10;
    localparam logic [5:0] Y0 = 6'b00_01_10;
    localparam logic [5:0] RR = 6'b00_00_11;
    localparam logic [5:0] G1 = 6'b10_00_01;
    localparam logic [5:0] Y1 = 6'b00_10_01;

    semaforo_ruas #(
        .N_RUAS(2), .T_VERDE(4), .T_MAX_VERDE(8), .T_AMARELO(2), .T_VERMELHO(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sensor   (sensor),
        .verde    (verde),
        .amarelo  (amarelo),
        .vermelho (vermelho),
        .rua_ativa(rua_ativa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sensor = 2'b00;
        repeat (2) step();
        chk("reset_lamps", 32'({verde, amarelo, vermelho}), 32'(G0));
        chk("reset_rua", 32'(rua_ativa), 32'd0);
        rst_n = 1'b1;
    endtask

    // Check lamps and active street for n consecutive cycles.
    task automatic fase(input string tag, input logic [5:0] lamps, input logic [0:0] rua, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_lamps"}, 32'({verde, amarelo, vermelho}), 32'(lamps));
            chk({tag, "_rua"}, 32'(rua_ativa), 32'(rua));
            step();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sensor = 2'b00;

        // No traffic: green stays on street 0.
        do_reset();
        fase("idle", G0, 1'b0, 20);

        // Gap-out to street 1, which then holds.
        do_reset();
        sensor = 2'b10;
        fase("gap_g0", G0, 1'b0, 4);
        fase("gap_y0", Y0, 1'b0, 2);
        fase("gap_r", RR, 1'b0, 1);
        fase("gap_g1", G1, 1'b1, 6);

        // Max-out alternation, period 22.
        do_reset();
        sensor = 2'b11;
        fase("max_g0", G0, 1'b0, 8);
        fase("max_y0", Y0, 1'b0, 2);
        fase("max_r0", RR, 1'b0, 1);
        fase("max_g1", G1, 1'b1, 8);
        fase("max_y1", Y1, 1'b1, 2);
        fase("max_r1", RR, 1'b1, 1);
        fase("max_g0b", G0, 1'b0, 8);
        fase("max_y0b", Y0, 1'b0, 1);

        // Request withdrawn during yellow: change completes and holds.
        do_reset();
        sensor = 2'b10;
        fase("wd_g0", G0, 1'b0, 4);
        sensor = 2'b00;
        fase("wd_y0", Y0, 1'b0, 2);
        fase("wd_r", RR, 1'b0, 1);
        fase("wd_g1", G1, 1'b1, 10);

        // Reset during the first yellow cycle.
        do_reset();
        sensor = 2'b10;
        fase("ry_g0", G0, 1'b0, 4);
        chk("ry_yellow", 32'({verde, amarelo, vermelho}), 32'(Y0));
        rst_n = 1'b0;
        step();
        chk("ry_lamps", 32'({verde, amarelo, vermelho}), 32'(G0));
        chk("ry_amarelo", 32'(amarelo), 32'd0);
        chk("ry_rua", 32'(rua_ativa), 32'd0);
        rst_n = 1'b1;

        // Random sensors: one lamp per street, at most one non-red street.
        sensor = 2'b00;
        for (int c = 0; c < 1000; c++) begin
            int um;
            int nao_verm;
            sensor = 2'($urandom_range(0, 3));
            step();
            um       = 1;
            nao_verm = 0;
            for (int s = 0; s < 2; s++) begin
                if ((32'(verde[s]) + 32'(amarelo[s]) + 32'(vermelho[s])) != 32'd1) um = 0;
                if (!vermelho[s]) nao_verm++;
            end
            chk("inv_one_lamp", 32'(um), 32'd1);
            chk("inv_non_red", 32'(nao_verm <= 1), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
